mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl.sv | 146 ++++++++++++++
 tb/tb_mc_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Opcode handshake, status inputs and datapath control outputs of mc_ctrl.
interface mc_ctrl_if #(
    parameter int OPW  = 2,
    parameter int CNTW = 16
);
    logic            op_valid;
    logic [OPW-1:0]  opcode;
    logic            zero;
    logic            mem_ready;
    logic            op_ready;
    logic            RegDst;
    logic            RegWrite;
    logic            ALUSrc;
    logic            Branch;
    logic            MemRead;
    logic            MemWrite;
    logic            MemtoReg;
    logic [1:0]      ALUOp;
    logic            PCWrite;
    logic            done;
    logic            illegal;
    logic            timeout;
    logic [CNTW-1:0] retired;

    modport master (
        output op_valid, opcode, zero, mem_ready,
        input  op_ready, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite,
               MemtoReg, ALUOp, PCWrite, done, illegal, timeout, retired
    );

    modport slave (
        input  op_valid, opcode, zero, mem_ready,
        output op_ready, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite,
               MemtoReg, ALUOp, PCWrite, done, illegal, timeout, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: IDLE -> EXEC -> (MEM) -> (WB) -> IDLE, with an
// ERR state for rejected opcodes and aborted memory stalls.
// OPW/CNTW must match the parameters of the connected mc_ctrl_if.
module mc_ctrl #(
    parameter int OPW     = 2,
    parameter int TIMEOUT = 15,
    parameter int CNTW    = 16
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, ERR} state_t;

    state_t          state, stateNext;
    logic [OPW-1:0]  opQ;
    logic [7:0]      stallCnt;
    logic            prevMem;   // ERR was entered from MEM (timeout path)
    logic [CNTW-1:0] retiredQ;

    logic [7:0] opIn, opQx;
    logic       legalIn;
    logic       isR, isLw, isSw, isBeq, isAddi, isJ;

    logic       opReady, regDst, regWrite, aluSrc, branch;
    logic       memRead, memWrite, memtoReg, pcWrite;
    logic       doneInt, illegalInt, timeoutInt;
    logic [1:0] aluOp;

    // Codes 4/5 cannot be expressed when OPW=2, so "< 6" covers both widths.
    assign opIn    = 8'(bus.opcode);
    assign opQx    = 8'(opQ);
    assign legalIn = (opIn < 8'd6);
    assign isR     = (opQx == 8'd0);
    assign isLw    = (opQx == 8'd1);
    assign isSw    = (opQx == 8'd2);
    assign isBeq   = (opQx == 8'd3);
    assign isAddi  = (opQx == 8'd4);
    assign isJ     = (opQx == 8'd5);

    // State, latched opcode, stall counter and retired counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opQ      <= '0;
            stallCnt <= '0;
            prevMem  <= 1'b0;
            retiredQ <= '0;
        end else begin
            state   <= stateNext;
            prevMem <= (state == MEM);
            if (state == IDLE && bus.op_valid)
                opQ <= bus.opcode;
            // MEM is only entered from EXEC, so the count is zero on entry.
            if (state != MEM)
                stallCnt <= '0;
            else if (!bus.mem_ready)
                stallCnt <= stallCnt + 8'd1;
            if (doneInt)
                retiredQ <= retiredQ + 1'b1;
        end
    end

    // Next state and control decode from state/op_q (plus zero, mem_ready).
    always_comb begin
        stateNext  = state;
        opReady    = 1'b0;
        regDst     = 1'b0;
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        branch     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memtoReg   = 1'b0;
        aluOp      = 2'b00;
        pcWrite    = 1'b0;
        doneInt    = 1'b0;
        illegalInt = 1'b0;
        timeoutInt = 1'b0;
        case (state)
            IDLE: begin
                opReady = 1'b1;
                if (bus.op_valid)
                    stateNext = legalIn ? EXEC : ERR;
            end
            EXEC: begin
                aluSrc = isLw | isSw | isAddi;
                if (isR)        aluOp = 2'b10;
                else if (isBeq) aluOp = 2'b01;
                if (isR || isAddi)
                    stateNext = WB;
                else if (isLw || isSw)
                    stateNext = MEM;
                else begin
                    branch    = isBeq;
                    pcWrite   = isJ | (isBeq & bus.zero);
                    doneInt   = 1'b1;
                    stateNext = IDLE;
                end
            end
            MEM: begin
                aluSrc   = 1'b1;
                memRead  = isLw;
                memWrite = isSw;
                if (bus.mem_ready) begin
                    if (isLw)
                        stateNext = WB;
                    else begin
                        doneInt   = 1'b1;
                        stateNext = IDLE;
                    end
                end else if (stallCnt == 8'(TIMEOUT - 1)) begin
                    stateNext = ERR;
                end
            end
            WB: begin
                regWrite  = 1'b1;
                doneInt   = 1'b1;
                regDst    = isR;
                memtoReg  = isLw;
                stateNext = IDLE;
            end
            ERR: begin
                illegalInt = ~prevMem;
                timeoutInt = prevMem;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.op_ready = opReady;
    assign bus.RegDst   = regDst;
    assign bus.RegWrite = regWrite;
    assign bus.ALUSrc   = aluSrc;
    assign bus.Branch   = branch;
    assign bus.MemRead  = memRead;
    assign bus.MemWrite = memWrite;
    assign bus.MemtoReg = memtoReg;
    assign bus.ALUOp    = aluOp;
    assign bus.PCWrite  = pcWrite;
    assign bus.done     = doneInt;
    assign bus.illegal  = illegalInt;
    assign bus.timeout  = timeoutInt;
    assign bus.retired  = retiredQ;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle vector table on an OPW=3/TIMEOUT=3
// instance, plus hand sequences on an OPW=2/CNTW=2 instance and a mid-MEM reset.
module tb_mc_ctrl;
    // {op_ready,RegDst,RegWrite,ALUSrc,Branch,MemRead,MemWrite,MemtoReg,ALUOp[1:0],PCWrite,done,illegal,timeout}
    localparam logic [13:0] O_IDLE  = 14'h2000;
    localparam logic [13:0] O_EXR   = 14'h0020;
    localparam logic [13:0] O_WBR   = 14'h1804;
    localparam logic [13:0] O_EXI   = 14'h0400;
    localparam logic [13:0] O_WBI   = 14'h0804;
    localparam logic [13:0] O_MLW   = 14'h0500;
    localparam logic [13:0] O_WBLW  = 14'h0844;
    localparam logic [13:0] O_MSW   = 14'h0480;
    localparam logic [13:0] O_MSWD  = 14'h0484;
    localparam logic [13:0] O_BEQ1  = 14'h021C;
    localparam logic [13:0] O_BEQ0  = 14'h0214;
    localparam logic [13:0] O_J     = 14'h000C;
    localparam logic [13:0] O_ILL   = 14'h0002;
    localparam logic [13:0] O_TMO   = 14'h0001;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic        z;
        logic        mr;
        logic [13:0] exp;
        logic [15:0] ret;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mc_ctrl_if #(.OPW(3), .CNTW(16)) if3 ();
    mc_ctrl_if #(.OPW(2), .CNTW(2))  if2 ();

    mc_ctrl #(.OPW(3), .TIMEOUT(3),  .CNTW(16)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    mc_ctrl #(.OPW(2), .TIMEOUT(15), .CNTW(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic logic [13:0] outs3();
        return {if3.op_ready, if3.RegDst, if3.RegWrite, if3.ALUSrc, if3.Branch,
                if3.MemRead, if3.MemWrite, if3.MemtoReg, if3.ALUOp, if3.PCWrite,
                if3.done, if3.illegal, if3.timeout};
    endfunction

    function automatic logic [13:0] outs2();
        return {if2.op_ready, if2.RegDst, if2.RegWrite, if2.ALUSrc, if2.Branch,
                if2.MemRead, if2.MemWrite, if2.MemtoReg, if2.ALUOp, if2.PCWrite,
                if2.done, if2.illegal, if2.timeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic v, input logic [2:0] op, input logic z, input logic mr,
                        input logic [13:0] exp, input logic [15:0] ret);
        vec_t r;
        r.v = v; r.op = op; r.z = z; r.mr = mr; r.exp = exp; r.ret = ret;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stallCycles;
        if3.op_valid = 0; if3.opcode = '0; if3.zero = 0; if3.mem_ready = 0;
        if2.op_valid = 0; if2.opcode = '0; if2.zero = 0; if2.mem_ready = 0;

        //    v  op z mr exp      ret
        addv(1, 0, 0, 0, O_IDLE, 0);  // accept R
        addv(1, 5, 0, 0, O_EXR,  0);  // op_valid ignored in EXEC
        addv(0, 0, 0, 0, O_WBR,  0);
        addv(1, 4, 0, 0, O_IDLE, 1);  // accept ADDI
        addv(0, 0, 0, 0, O_EXI,  1);
        addv(0, 0, 0, 0, O_WBI,  1);
        addv(1, 3, 0, 0, O_IDLE, 2);  // BEQ taken
        addv(0, 0, 1, 0, O_BEQ1, 2);
        addv(1, 3, 0, 0, O_IDLE, 3);  // BEQ not taken
        addv(0, 0, 0, 0, O_BEQ0, 3);
        addv(1, 5, 0, 0, O_IDLE, 4);  // J
        addv(0, 0, 0, 0, O_J,    4);
        addv(1, 1, 0, 0, O_IDLE, 5);  // LW, one stall
        addv(0, 0, 0, 0, O_EXI,  5);
        addv(0, 0, 0, 0, O_MLW,  5);
        addv(0, 0, 0, 1, O_MLW,  5);
        addv(0, 0, 0, 0, O_WBLW, 5);
        addv(1, 2, 0, 0, O_IDLE, 6);  // SW, no stall
        addv(0, 0, 0, 0, O_EXI,  6);
        addv(0, 0, 0, 1, O_MSWD, 6);
        addv(1, 6, 0, 0, O_IDLE, 7);  // illegal 6
        addv(0, 0, 0, 0, O_ILL,  7);
        addv(0, 0, 0, 0, O_IDLE, 7);
        addv(1, 7, 0, 0, O_IDLE, 7);  // illegal 7
        addv(0, 0, 0, 0, O_ILL,  7);
        addv(1, 2, 0, 0, O_IDLE, 7);  // SW, times out after 3 stalls
        addv(0, 0, 0, 0, O_EXI,  7);
        addv(0, 0, 0, 0, O_MSW,  7);
        addv(0, 0, 0, 0, O_MSW,  7);
        addv(0, 0, 0, 0, O_MSW,  7);
        addv(0, 0, 0, 0, O_TMO,  7);
        addv(1, 1, 0, 0, O_IDLE, 7);  // LW, two stalls then ready
        addv(0, 0, 0, 0, O_EXI,  7);
        addv(0, 0, 0, 0, O_MLW,  7);
        addv(0, 0, 0, 0, O_MLW,  7);
        addv(0, 0, 0, 1, O_MLW,  7);
        addv(0, 0, 0, 0, O_WBLW, 7);
        addv(0, 0, 1, 1, O_IDLE, 8);  // inputs ignored in IDLE

        #2;
        chk("reset outs3", 32'(outs3()), 32'(O_IDLE));
        chk("reset ret3", 32'(if3.retired), 32'd0);
        chk("reset outs2", 32'(outs2()), 32'(O_IDLE));
        chk("reset ret2", 32'(if2.retired), 32'd0);
        @(negedge clk);
        rst = 0;

        foreach (tbl[i]) begin
            @(negedge clk);
            if3.op_valid = tbl[i].v; if3.opcode = tbl[i].op;
            if3.zero = tbl[i].z; if3.mem_ready = tbl[i].mr;
            #1;
            chk($sformatf("row%0d outs", i), 32'(outs3()), 32'(tbl[i].exp));
            chk($sformatf("row%0d retired", i), 32'(if3.retired), 32'(tbl[i].ret));
        end
        if3.op_valid = 0; if3.zero = 0; if3.mem_ready = 0;

        // OPW=2: opcode 3 is BEQ
        @(negedge clk); if2.op_valid = 1; if2.opcode = 2'd3; if2.zero = 1;
        @(negedge clk); if2.op_valid = 0; #1;
        chk("opw2 beq exec", 32'(outs2()), 32'(O_BEQ1));
        @(negedge clk); if2.zero = 0; #1;
        chk("opw2 beq retired", 32'(if2.retired), 32'd1);

        // OPW=2 SW with mem_ready held low: 15 stall cycles then timeout
        @(negedge clk); if2.op_valid = 1; if2.opcode = 2'd2;
        @(negedge clk); if2.op_valid = 0; #1;
        chk("sw exec", 32'(outs2()), 32'(O_EXI));
        stallCycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (!if2.MemWrite) break;
            stallCycles++;
            chk($sformatf("sw stall%0d", k), 32'(outs2()), 32'(O_MSW));
        end
        chk("sw stall count", 32'(stallCycles), 32'd15);
        chk("sw timeout err", 32'(outs2()), 32'(O_TMO));
        @(negedge clk); #1;
        chk("sw after timeout", 32'(outs2()), 32'(O_IDLE));
        chk("sw retired kept", 32'(if2.retired), 32'd1);

        // 2-bit retired counter wraps 3 -> 0
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); if2.op_valid = 1; if2.opcode = 2'd3;
            @(negedge clk); if2.op_valid = 0;
        end
        @(negedge clk); #1;
        chk("retired wrap", 32'(if2.retired), 32'd0);

        // Asynchronous reset during an SW stall
        @(negedge clk); if3.op_valid = 1; if3.opcode = 3'd2; if3.mem_ready = 0;
        @(negedge clk); if3.op_valid = 0;
        @(negedge clk); #1;
        chk("mid mem stall", 32'(outs3()), 32'(O_MSW));
        @(negedge clk); #2;
        rst = 1; #1;
        chk("async MemWrite", 32'(if3.MemWrite), 32'd0);
        chk("async outs", 32'(outs3()), 32'(O_IDLE));
        chk("async retired", 32'(if3.retired), 32'd0);
        @(negedge clk); rst = 0;
        @(negedge clk); if3.op_valid = 1; if3.opcode = 3'd0;
        @(negedge clk); if3.op_valid = 0; #1;
        chk("post rst exec", 32'(outs3()), 32'(O_EXR));
        @(negedge clk); #1;
        chk("post rst wb", 32'(outs3()), 32'(O_WBR));
        @(negedge clk); #1;
        chk("post rst retired", 32'(if3.retired), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
